// File: rtl/mdu_ctrl.sv
// Iterative RV64M multiply/divide unit: shift-add multiply, restoring divide,
// STEP bits per iteration cycle, busy stall and one-cycle done pulse.
module mdu_ctrl #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [31:0]     ir,
  input  logic            start,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] mdu_out
);

  localparam int unsigned CNT_W = 7;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [6:0] OPC_OP   = 7'b0110011;
  localparam logic [6:0] OPC_OP32 = 7'b0111011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  logic [1:0]        r_state, w_state_nxt;
  logic [2:0]        r_op, w_op_nxt;
  logic              r_w, w_w_nxt;
  logic              r_neg_a, w_neg_a_nxt;
  logic              r_neg_b, w_neg_b_nxt;
  logic [2*XLEN-1:0] r_acc, w_acc_nxt;
  logic [XLEN-1:0]   r_opnd, w_opnd_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic [XLEN-1:0]   r_mdu_out, w_mdu_out_nxt;

  // Instruction decode and operand preparation for the accept cycle
  logic [2:0]      w_op;
  logic            w_is_w, w_legal, w_accept, w_is_div;
  logic            w_sign_a, w_sign_b, w_neg_a, w_neg_b;
  logic [XLEN-1:0] w_a_ext, w_b_ext, w_mag_a, w_mag_b, w_min;
  logic            w_div_zero, w_ovf, w_special;
  logic [XLEN-1:0] w_special_res;
  logic [CNT_W-1:0] w_n_m1;
  logic            w_unused;

  assign w_unused = ^{ir[24:15], ir[11:7]};
  assign w_op     = ir[14:12];
  assign w_is_w   = (ir[6:0] == OPC_OP32);
  assign w_legal  = (ir[31:25] == F7_MULDIV) &&
                    ((ir[6:0] == OPC_OP) || (w_is_w && ((w_op == 3'b000) || w_op[2])));
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE)) && w_legal;
  assign w_is_div = w_op[2];
  assign w_sign_a = (w_op == 3'b001) || (w_op == 3'b010) || (w_op == 3'b100) || (w_op == 3'b110);
  assign w_sign_b = (w_op == 3'b001) || (w_op == 3'b100) || (w_op == 3'b110);
  assign w_a_ext  = w_is_w ? (w_sign_a ? {{(XLEN-32){a[31]}}, a[31:0]} : {{(XLEN-32){1'b0}}, a[31:0]}) : a;
  assign w_b_ext  = w_is_w ? (w_sign_b ? {{(XLEN-32){b[31]}}, b[31:0]} : {{(XLEN-32){1'b0}}, b[31:0]}) : b;
  assign w_neg_a  = w_sign_a & w_a_ext[XLEN-1];
  assign w_neg_b  = w_sign_b & w_b_ext[XLEN-1];
  assign w_mag_a  = w_neg_a ? (~w_a_ext + XLEN'(1)) : w_a_ext;
  assign w_mag_b  = w_neg_b ? (~w_b_ext + XLEN'(1)) : w_b_ext;
  assign w_min    = w_is_w ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
  assign w_div_zero = w_is_div && (w_b_ext == '0);
  assign w_ovf    = w_is_div && !w_op[0] && (w_a_ext == w_min) && (w_b_ext == '1);
  assign w_special = w_div_zero || w_ovf;
  assign w_n_m1   = w_is_w ? CNT_W'(32 / STEP - 1) : CNT_W'(XLEN / STEP - 1);

  // Result of the cases that skip the iteration loop
  always_comb begin
    w_special_res = '0;
    if (w_div_zero)
      w_special_res = w_op[1] ? (w_is_w ? {{(XLEN-32){a[31]}}, a[31:0]} : a) : '1;
    else if (w_ovf)
      w_special_res = w_op[1] ? '0 : w_a_ext;
  end

  // STEP iterations of shift-add (multiply) or restoring subtract (divide)
  logic [2*XLEN-1:0] w_it_acc;
  logic [XLEN:0]     w_it_sum, w_it_rem;
  logic              w_it_ge;
  always_comb begin
    w_it_acc = r_acc;
    w_it_sum = '0;
    w_it_rem = '0;
    w_it_ge  = 1'b0;
    for (int unsigned s = 0; s < STEP; s++) begin
      if (r_op[2]) begin
        w_it_rem = {w_it_acc[2*XLEN-1:XLEN], w_it_acc[XLEN-1]};
        w_it_ge  = (w_it_rem >= {1'b0, r_opnd});
        if (w_it_ge) w_it_rem = w_it_rem - {1'b0, r_opnd};
        w_it_acc = {w_it_rem[XLEN-1:0], w_it_acc[XLEN-2:0], w_it_ge};
      end else begin
        w_it_sum = {1'b0, w_it_acc[2*XLEN-1:XLEN]} + (w_it_acc[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
        w_it_acc = {w_it_sum, w_it_acc[XLEN-1:1]};
      end
    end
  end

  // Sign fix-up, half/quotient/remainder select and W sign-extension
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_sel, w_fix_res;
  always_comb begin
    w_prod = (r_neg_a ^ r_neg_b) ? (~r_acc + (2*XLEN)'(1)) : r_acc;
    w_quo  = (r_neg_a ^ r_neg_b) ? (~r_acc[XLEN-1:0] + XLEN'(1)) : r_acc[XLEN-1:0];
    w_rem  = r_neg_a ? (~r_acc[2*XLEN-1:XLEN] + XLEN'(1)) : r_acc[2*XLEN-1:XLEN];
    w_sel  = '0;
    w_fix_res = '0;
    if (r_op[2]) begin
      w_sel     = r_op[1] ? w_rem : w_quo;
      w_fix_res = r_w ? {{(XLEN-32){w_sel[31]}}, w_sel[31:0]} : w_sel;
    end else if (r_op[1:0] == 2'b00) begin
      w_fix_res = r_w ? {{(XLEN-32){w_prod[XLEN-1]}}, w_prod[XLEN-1:XLEN-32]} : w_prod[XLEN-1:0];
    end else begin
      w_fix_res = w_prod[2*XLEN-1:XLEN];
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt   = r_state;
    w_op_nxt      = r_op;
    w_w_nxt       = r_w;
    w_neg_a_nxt   = r_neg_a;
    w_neg_b_nxt   = r_neg_b;
    w_acc_nxt     = r_acc;
    w_opnd_nxt    = r_opnd;
    w_cnt_nxt     = r_cnt;
    w_mdu_out_nxt = r_mdu_out;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_ITER: begin
          w_acc_nxt = w_it_acc;
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt == '0) w_state_nxt = S_FIX;
        end
        S_FIX: begin
          w_mdu_out_nxt = w_fix_res;
          w_state_nxt   = S_DONE;
        end
        default: begin
          w_state_nxt = S_IDLE;
          if (w_accept) begin
            w_op_nxt    = w_op;
            w_w_nxt     = w_is_w;
            w_neg_a_nxt = w_neg_a;
            w_neg_b_nxt = w_neg_b;
            w_cnt_nxt   = w_n_m1;
            if (w_special) begin
              w_mdu_out_nxt = w_special_res;
              w_state_nxt   = S_DONE;
            end else if (w_is_div) begin
              w_opnd_nxt  = w_mag_b;
              w_acc_nxt   = {{XLEN{1'b0}}, (w_is_w ? {w_mag_a[31:0], {(XLEN-32){1'b0}}} : w_mag_a)};
              w_state_nxt = S_ITER;
            end else begin
              w_opnd_nxt  = w_mag_a;
              w_acc_nxt   = {{XLEN{1'b0}}, w_mag_b};
              w_state_nxt = S_ITER;
            end
          end
        end
      endcase
    end
    w_busy_nxt = (w_state_nxt == S_ITER) || (w_state_nxt == S_FIX);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_w       <= 1'b0;
      r_neg_a   <= 1'b0;
      r_neg_b   <= 1'b0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_mdu_out <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_op      <= w_op_nxt;
      r_w       <= w_w_nxt;
      r_neg_a   <= w_neg_a_nxt;
      r_neg_b   <= w_neg_b_nxt;
      r_acc     <= w_acc_nxt;
      r_opnd    <= w_opnd_nxt;
      r_cnt     <= w_cnt_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_mdu_out <= w_mdu_out_nxt;
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign mdu_out = r_mdu_out;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_mdu_ctrl;

  localparam int unsigned XLEN = 64;
  localparam int unsigned STEP = 1;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] a, b;
  logic [31:0] ir;
  logic        start, flush;
  logic        busy, done;
  logic [63:0] mdu_out;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_ctrl #(.XLEN(XLEN), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .ir(ir), .start(start), .flush(flush),
    .busy(busy), .done(done), .mdu_out(mdu_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [2:0] op, input bit w, input bit m);
    return {(m ? 7'b0000001 : 7'b0000000), 5'd2, 5'd1, op, 5'd3, (w ? 7'b0111011 : 7'b0110011)};
  endfunction

  function automatic logic [63:0] sext32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  function automatic bit is_special(input logic [2:0] op, input bit w, input logic [63:0] av, input logic [63:0] bv);
    if (!op[2]) return 0;
    if (w) return (bv[31:0] == 32'h0) || (!op[0] && av[31:0] == 32'h8000_0000 && bv[31:0] == 32'hFFFF_FFFF);
    return (bv == 64'h0) || (!op[0] && av == MIN64 && bv == '1);
  endfunction

  // Reference result from the architectural definition of each M op
  function automatic logic [63:0] model(input logic [2:0] op, input bit w, input logic [63:0] av, input logic [63:0] bv);
    logic signed [127:0] pa, pb, pp;
    longint sa, sb;
    int sa32, sb32;
    logic [31:0] ua, ub, r32;
    sa = av; sb = bv; ua = av[31:0]; ub = bv[31:0]; sa32 = av[31:0]; sb32 = bv[31:0];
    if (!w) begin
      case (op)
        3'd0: return av * bv;
        3'd1: begin pa = $signed(av); pb = $signed(bv); pp = pa * pb; return pp[127:64]; end
        3'd2: begin pa = $signed(av); pb = {64'h0, bv}; pp = pa * pb; return pp[127:64]; end
        3'd3: begin pa = {64'h0, av}; pb = {64'h0, bv}; pp = pa * pb; return pp[127:64]; end
        3'd4: begin
          if (bv == 0) return '1;
          if (av == MIN64 && bv == '1) return av;
          return sa / sb;
        end
        3'd5: return (bv == 0) ? '1 : av / bv;
        3'd6: begin
          if (bv == 0) return av;
          if (av == MIN64 && bv == '1) return 64'h0;
          return sa % sb;
        end
        default: return (bv == 0) ? av : av % bv;
      endcase
    end else begin
      case (op)
        3'd0: begin r32 = ua * ub; return sext32(r32); end
        3'd4: begin
          if (ub == 0) return '1;
          if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) return sext32(ua);
          r32 = sa32 / sb32; return sext32(r32);
        end
        3'd5: begin if (ub == 0) return '1; r32 = ua / ub; return sext32(r32); end
        3'd6: begin
          if (ub == 0) return sext32(ua);
          if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) return 64'h0;
          r32 = sa32 % sb32; return sext32(r32);
        end
        default: begin if (ub == 0) return sext32(ua); r32 = ua % ub; return sext32(r32); end
      endcase
    end
  endfunction

  task automatic issue(input logic [2:0] op, input bit w, input logic [63:0] av, input logic [63:0] bv);
    a = av; b = bv; ir = mk_ir(op, w, 1'b1); start = 1'b1;
  endtask

  // Expects inputs already driven ahead of the accept edge; returns in the done cycle
  task automatic wait_done(input logic [2:0] op, input bit w, input logic [63:0] av, input logic [63:0] bv, input string tag);
    int lat, k, bad;
    bit seen;
    logic [63:0] exp;
    lat = is_special(op, w, av, bv) ? 1 : int'(((w ? 32 : XLEN) / STEP) + 2);
    exp = model(op, w, av, bv);
    @(posedge clk); #1;
    start = 1'b0; a = {$urandom, $urandom}; b = {$urandom, $urandom}; ir = $urandom;
    k = 1; seen = 0; bad = 0;
    while (k <= lat + 4 && !seen) begin
      if (busy !== (k < lat)) bad++;
      if (done === 1'b1) seen = 1;
      else begin @(posedge clk); #1; k++; end
    end
    check({tag, " done_cycle"}, 64'(seen ? k : 0), 64'(lat));
    check({tag, " busy"}, 64'(bad), 64'd0);
    check({tag, " result"}, mdu_out, exp);
  endtask

  task automatic do_op(input logic [2:0] op, input bit w, input logic [63:0] av, input logic [63:0] bv, input string tag);
    @(negedge clk);
    issue(op, w, av, bv);
    wait_done(op, w, av, bv, tag);
  endtask

  logic [63:0] prev;
  logic [2:0]  rop;
  bit          rw;
  logic [63:0] ra, rb;
  int          mode, cnt;

  initial begin
    rst = 1'b1; a = '0; b = '0; ir = '0; start = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset out", mdu_out, 64'd0);
    @(negedge clk); rst = 1'b0;

    do_op(3'd0, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, "mul_7_m3");
    do_op(3'd3, 0, '1, '1, "mulhu_ones");
    do_op(3'd2, 0, '1, 64'd2, "mulhsu_m1_2");
    do_op(3'd1, 0, MIN64, MIN64, "mulh_min");
    do_op(3'd4, 0, -64'sd7, 64'd2, "div_m7_2");
    do_op(3'd6, 0, -64'sd7, 64'd2, "rem_m7_2");
    do_op(3'd5, 1, 64'h1_0000_0007, 64'd2, "divuw");
    do_op(3'd5, 0, 64'd5, 64'd0, "divu_by0");
    do_op(3'd6, 0, MIN64, '1, "rem_ovf");
    do_op(3'd4, 0, MIN64, '1, "div_ovf");
    do_op(3'd4, 1, 64'h1234_5678_8000_0000, 64'h0000_0001_FFFF_FFFF, "divw_ovf");
    do_op(3'd7, 1, 64'h0000_0000_F000_0001, 64'h7_0000_0000, "remuw_by0");
    do_op(3'd0, 1, 64'h0000_0001_FFFF_FFFD, 64'h0000_0000_0000_0007, "mulw");

    // Flush during a divide leaves the previous result in place
    do_op(3'd5, 0, 64'd100, 64'd7, "pre_flush");
    prev = model(3'd5, 0, 64'd100, 64'd7);
    @(negedge clk); issue(3'd4, 0, -64'sd1000, 64'd7);
    @(posedge clk); #1; start = 1'b0;
    repeat (19) @(posedge clk);
    #1; flush = 1'b1; start = 1'b1; ir = mk_ir(3'd0, 0, 1'b1);
    @(posedge clk); #1; flush = 1'b0; start = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush done", 64'(done), 64'd0);
    check("flush out", mdu_out, prev);
    cnt = 0;
    repeat (70) begin @(posedge clk); #1; if (done || busy) cnt++; end
    check("flush quiet", 64'(cnt), 64'd0);
    do_op(3'd4, 0, -64'sd1000, 64'd7, "post_flush");

    // Back-to-back accept from the DONE cycle
    do_op(3'd0, 0, 64'd12345, 64'd678, "b2b_first");
    issue(3'd0, 0, 64'hDEAD_BEEF, 64'hFFFF_0000_1111);
    wait_done(3'd0, 0, 64'hDEAD_BEEF, 64'hFFFF_0000_1111, "b2b_second");
    @(posedge clk); #1;
    check("done pulse width", 64'(done), 64'd0);

    // Non-M and illegal W encodings are ignored
    @(negedge clk); a = 64'd5; b = 64'd3; ir = mk_ir(3'd0, 0, 1'b0); start = 1'b1;
    @(posedge clk); #1;
    check("add ignored busy", 64'(busy), 64'd0);
    check("add ignored done", 64'(done), 64'd0);
    ir = mk_ir(3'd1, 1, 1'b1);
    @(posedge clk); #1; start = 1'b0;
    check("mulhw ignored busy", 64'(busy), 64'd0);

    // Reset during an operation
    @(negedge clk); issue(3'd3, 0, '1, 64'd3);
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #2; rst = 1'b1; #1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst out", mdu_out, 64'd0);
    @(negedge clk); rst = 1'b0;
    cnt = 0;
    repeat (70) begin @(posedge clk); #1; if (done) cnt++; end
    check("midrst no done", 64'(cnt), 64'd0);

    // Randomized operations
    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      rw  = 1'($urandom_range(0, 1));
      if (rw && rop != 3'd0 && !rop[2]) rw = 0;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      mode = $urandom_range(0, 9);
      case (mode)
        0: rb = rw ? {$urandom, 32'h0} : 64'h0;
        1: begin
          ra = rw ? {$urandom, 32'h8000_0000} : MIN64;
          rb = rw ? {$urandom, 32'hFFFF_FFFF} : '1;
        end
        2: begin ra = 64'($urandom_range(0, 1000)); rb = -64'($urandom_range(1, 50)); end
        3: rb = 64'($urandom_range(1, 9));
        default: ;
      endcase
      do_op(rop, rw, ra, rb, $sformatf("rand%0d_op%0d_w%0d", i, rop, rw));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
